// File: rtl/relu_requant.sv
// relu_requant: streams a conv feature map through scale/round/shift/clamp (+ReLU) into a second memory
module relu_requant #(
    parameter int CHANNELS   = 64,
    parameter int HEIGHT     = 2,
    parameter int WIDTH      = 2,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            mult,
    input  logic [3:0]            shift,
    input  logic                  relu_en,
    output logic                  busy,
    output logic                  done,
    output logic [ADDR_WIDTH-1:0] input_addr,
    output logic                  input_en,
    input  logic [DATA_WIDTH-1:0] input_data,
    output logic [ADDR_WIDTH-1:0] output_addr,
    output logic [DATA_WIDTH-1:0] output_data,
    output logic                  output_we,
    output logic                  output_en
);
    localparam int N = CHANNELS * HEIGHT * WIDTH;
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(N - 1);
    localparam logic signed [17:0] HI = 18'((1 << (DATA_WIDTH - 1)) - 1);
    localparam logic signed [17:0] MIN = -HI - 18'sd1;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t state;
    logic [7:0] mult_q;
    logic [3:0] shift_q;
    logic relu_q;
    logic v_rd, v_x, v_p;
    logic signed [DATA_WIDTH-1:0] x;
    logic signed [17:0] p, rnd, r, q, lo;
    logic [DATA_WIDTH-1:0] y;

    assign output_en = output_we;

    // Round-half-up, arithmetic shift, then clamp to [lo, HI]; lo is 0 with ReLU
    always_comb begin
        rnd = (shift_q != 4'd0) ? (18'sd1 <<< (shift_q - 4'd1)) : 18'sd0;
        r = p + rnd;
        q = r >>> shift_q;
        lo = relu_q ? 18'sd0 : MIN;
        y = DATA_WIDTH'((q > HI) ? HI : (q < lo) ? lo : q);
    end

    // Control FSM: latches the pass configuration, issues reads, reports completion
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy <= 1'b0;
            done <= 1'b0;
            input_en <= 1'b0;
            input_addr <= '0;
            mult_q <= '0;
            shift_q <= '0;
            relu_q <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    mult_q <= mult;
                    shift_q <= shift;
                    relu_q <= relu_en;
                    busy <= 1'b1;
                    input_en <= 1'b1;
                    input_addr <= '0;
                    state <= RUN;
                end
                RUN: if (input_addr == LAST) begin
                    input_en <= 1'b0;
                    state <= DRAIN;
                end else begin
                    input_addr <= input_addr + ADDR_WIDTH'(1);
                end
                DRAIN: if (output_we && output_addr == LAST) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                    state <= DONE;
                end
                DONE: if (!start) begin
                    done <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: capture read data, multiply, then register the write; addresses follow the burst
    always_ff @(posedge clk) begin
        if (rst) begin
            v_rd <= 1'b0;
            v_x <= 1'b0;
            v_p <= 1'b0;
            x <= '0;
            p <= '0;
            output_we <= 1'b0;
            output_addr <= '0;
            output_data <= '0;
        end else begin
            v_rd <= input_en;
            v_x <= v_rd;
            v_p <= v_x;
            x <= input_data;
            p <= $signed(18'(x)) * $signed(18'({1'b0, mult_q}));
            output_we <= v_p;
            output_data <= y;
            if (v_p) output_addr <= output_we ? output_addr + ADDR_WIDTH'(1) : '0;
        end
    end
endmodule

// File: tb/tb_relu_requant.sv
// tb_relu_requant: directed passes checked cycle-by-cycle against a behavioural requantizer model
module tb_relu_requant;
    localparam int N = 256;

    logic clk = 1'b0;
    logic rst, start, relu_en;
    logic [7:0] mult;
    logic [3:0] shift;
    logic busy, done, input_en, output_we, output_en;
    logic [7:0] input_addr, output_addr, output_data;
    logic [7:0] input_data;

    logic signed [7:0] mem [N];
    logic [7:0] out_mem [N];

    int compared = 0, mismatched = 0;
    bit chk_on = 1'b0, active = 1'b0;
    int cyc = 0, em = 0, es = 0;
    bit er = 1'b0;
    int k;

    relu_requant dut (
        .clk(clk), .rst(rst), .start(start), .mult(mult), .shift(shift), .relu_en(relu_en),
        .busy(busy), .done(done), .input_addr(input_addr), .input_en(input_en),
        .input_data(input_data), .output_addr(output_addr), .output_data(output_data),
        .output_we(output_we), .output_en(output_en)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ref_y(int xv, int m, int s, bit relu);
        int d = 1 << s;
        int v = xv * m + d / 2;
        int q = (v >= 0) ? v / d : -((-v + d - 1) / d);
        int lo = relu ? 0 : -128;
        int yv = (q > 127) ? 127 : (q < lo) ? lo : q;
        return 8'(yv);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Synchronous-read source memory and destination memory
    always @(posedge clk) begin
        if (input_en) input_data <= mem[input_addr];
        if (output_we) out_mem[output_addr] <= output_data;
    end

    // Pass tracker: cycle number since start acceptance, with the configuration latched then
    always @(posedge clk) begin
        if (rst) active = 1'b0;
        else if (!active) begin
            if (start) begin
                active = 1'b1; cyc = 0; em = int'(mult); es = int'(shift); er = relu_en;
            end
        end else if (cyc >= N + 5 && !start) active = 1'b0;
        if (active) cyc++;
    end

    // Per-cycle comparison of every output against the expected schedule
    always @(negedge clk) begin
        if (chk_on) begin
            chk("input_en", input_en, active && cyc <= N);
            if (active && cyc <= N) chk("input_addr", input_addr, cyc - 1);
            chk("output_we", output_we, active && cyc >= 5 && cyc <= N + 4);
            chk("output_en", output_en, active && cyc >= 5 && cyc <= N + 4);
            if (active && cyc >= 5 && cyc <= N + 4) begin
                chk("output_addr", output_addr, cyc - 5);
                chk("output_data", output_data, ref_y(mem[cyc - 5], em, es, er));
            end
            chk("busy", busy, active && cyc <= N + 4);
            chk("done", done, active && cyc >= N + 5);
        end
    end

    task automatic run_pass(input logic [7:0] m, input logic [3:0] s, input logic r,
                            input bit poke, input int rst_at);
        mult = m; shift = s; relu_en = r; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (k = 1; k < 700; k++) begin
            if (done) break;
            if (k == rst_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_input_addr", input_addr, 0);
                chk("rst_output_addr", output_addr, 0);
                chk("rst_output_data", output_data, 0);
                chk("rst_busy", busy, 0);
                rst = 1'b0;
                repeat (20) @(negedge clk);
                return;
            end
            if (poke && k == 20) start = 1'b1;
            if (poke && k == 21) start = 1'b0;
            if (poke && k == 30) mult = 8'd7;
            if (k == N + 2) start = 1'b1;
            @(negedge clk);
        end
        chk("done_seen", done, 1);
        chk("done_cycle", k, 261);
        repeat (3) @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; mult = '0; shift = '0; relu_en = 1'b0;
        for (int i = 0; i < N; i++) mem[i] = 8'($urandom);
        repeat (3) @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_done", done, 0);
        chk("reset_input_en", input_en, 0);
        chk("reset_input_addr", input_addr, 0);
        chk("reset_output_we", output_we, 0);
        chk("reset_output_en", output_en, 0);
        chk("reset_output_addr", output_addr, 0);
        chk("reset_output_data", output_data, 0);
        rst = 1'b0;
        @(posedge clk);
        chk_on = 1'b1;
        @(negedge clk);

        chk("model_a", ref_y(-7, 3, 2, 0), 8'hFB);
        chk("model_b", ref_y(127, 255, 15, 0), 8'h01);
        chk("model_c", ref_y(-128, 255, 0, 0), 8'h80);

        mem[0] = -8'sd5; mem[1] = 8'sd100; mem[2] = 8'sd0; mem[3] = 8'sd127;
        run_pass(8'd1, 4'd0, 1'b1, 1'b0, 0);
        chk("relu_0", out_mem[0], 8'h00);
        chk("relu_1", out_mem[1], 8'h64);
        chk("relu_2", out_mem[2], 8'h00);
        chk("relu_3", out_mem[3], 8'h7F);

        run_pass(8'd1, 4'd0, 1'b0, 1'b0, 0);
        chk("norelu_0", out_mem[0], 8'hFB);
        chk("norelu_1", out_mem[1], 8'h64);
        chk("norelu_3", out_mem[3], 8'h7F);

        mem[0] = 8'sd10; mem[1] = -8'sd7; mem[2] = 8'sd2;
        run_pass(8'd3, 4'd2, 1'b0, 1'b1, 0);
        chk("round_0", out_mem[0], 8'h08);
        chk("round_1", out_mem[1], 8'hFB);
        chk("round_2", out_mem[2], 8'h02);

        mem[0] = 8'sd127; mem[1] = -8'sd128;
        run_pass(8'd255, 4'd0, 1'b0, 1'b0, 0);
        chk("sat_hi", out_mem[0], 8'h7F);
        chk("sat_lo", out_mem[1], 8'h80);

        run_pass(8'd255, 4'd15, 1'b0, 1'b0, 0);
        chk("shift15", out_mem[0], 8'h01);

        run_pass(8'd1, 4'd0, 1'b0, 1'b0, 100);
        run_pass(8'd2, 4'd1, 1'b1, 1'b0, 0);
        chk("after_rst_0", out_mem[0], ref_y(mem[0], 2, 1, 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d mismatched %0d", compared, mismatched);
        $fatal(1);
    end
endmodule
